// File: rtl/pito_irq_ctrl.sv
// pito_irq_ctrl: per-hart machine interrupt controller for the barrel core.
// Holds MSIP/MVIP pending registers and registered MTIP/MEIP levels, and
// builds the MIP image. Each hart has its own FSM that freezes one mcause per
// trap request.
// Optional macro PITO_IRQ_SYNC_EN: adds 2-flop synchronizers on timer/ext levels.
module pito_irq_ctrl #(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS),
  parameter int XPR_LEN        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_HARTS-1:0]         sw_irq_set_i,
  input  logic [NUM_HARTS-1:0]         sw_irq_clr_i,
  input  logic [NUM_HARTS-1:0]         timer_irq_i,
  input  logic [NUM_HARTS-1:0]         ext_irq_i,
  input  logic [NUM_HARTS-1:0]         mvu_irq_i,
  input  logic [NUM_HARTS-1:0]         mstatus_mie_i,
  input  logic [NUM_HARTS*XPR_LEN-1:0] mie_i,
  input  logic [NUM_HARTS-1:0]         irq_ack_i,
  output logic [NUM_HARTS*XPR_LEN-1:0] mip_o,
  output logic [NUM_HARTS-1:0]         irq_req_o,
  output logic [NUM_HARTS*XPR_LEN-1:0] irq_cause_o
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  localparam int MSIP_BIT = 3;
  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;
  localparam int MVIP_BIT = 16;

  localparam logic [XPR_LEN-1:0] CAUSE_MEI = XPR_LEN'(32'h8000000B);
  localparam logic [XPR_LEN-1:0] CAUSE_MSI = XPR_LEN'(32'h80000003);
  localparam logic [XPR_LEN-1:0] CAUSE_MTI = XPR_LEN'(32'h80000007);
  localparam logic [XPR_LEN-1:0] CAUSE_MVI = XPR_LEN'(32'h80000010);

  logic [NUM_HARTS-1:0] timer_lvl, ext_lvl;
  logic [NUM_HARTS-1:0] msip_q, msip_d, mvip_q, mvip_d;
  logic [NUM_HARTS-1:0] mtip_q, mtip_d, meip_q, meip_d;
  logic [NUM_HARTS-1:0] en_msi, en_mti, en_mei, en_mvi, eligible, mvip_clr;
  state_t [NUM_HARTS-1:0] state_q, state_d;
  logic [NUM_HARTS-1:0][XPR_LEN-1:0] cause_q, cause_d;

  // Only MIE bits 3/7/11/16 matter; the rest of the word is deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{mie_i, HART_CNT_WIDTH[0]};

`ifdef PITO_IRQ_SYNC_EN
  logic [NUM_HARTS-1:0] timer_s1_q, timer_s2_q, ext_s1_q, ext_s2_q;

  // Two-stage synchronizers for the asynchronous level sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_s1_q <= '0;
      timer_s2_q <= '0;
      ext_s1_q   <= '0;
      ext_s2_q   <= '0;
    end else begin
      timer_s1_q <= timer_irq_i;
      timer_s2_q <= timer_s1_q;
      ext_s1_q   <= ext_irq_i;
      ext_s2_q   <= ext_s1_q;
    end
  end

  assign timer_lvl = timer_s2_q;
  assign ext_lvl   = ext_s2_q;
`else
  assign timer_lvl = timer_irq_i;
  assign ext_lvl   = ext_irq_i;
`endif

  // Pending-bit next state; a set pulse always beats a same-cycle clear.
  always_comb begin
    mvip_clr = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mvip_clr[h] = (state_q[h] == REQ) && irq_ack_i[h] && (cause_q[h] == CAUSE_MVI);
    end
    msip_d = sw_irq_set_i | (msip_q & ~sw_irq_clr_i);
    mvip_d = mvu_irq_i | (mvip_q & ~mvip_clr);
    mtip_d = timer_lvl;
    meip_d = ext_lvl;
  end

  // Pending registers; these are the MIP image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_q <= '0;
      mvip_q <= '0;
      mtip_q <= '0;
      meip_q <= '0;
    end else begin
      msip_q <= msip_d;
      mvip_q <= mvip_d;
      mtip_q <= mtip_d;
      meip_q <= meip_d;
    end
  end

  // MIP image assembly and per-hart enable masking.
  always_comb begin
    mip_o    = '0;
    en_msi   = '0;
    en_mti   = '0;
    en_mei   = '0;
    en_mvi   = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mip_o[h*XPR_LEN + MSIP_BIT] = msip_q[h];
      mip_o[h*XPR_LEN + MTIP_BIT] = mtip_q[h];
      mip_o[h*XPR_LEN + MEIP_BIT] = meip_q[h];
      mip_o[h*XPR_LEN + MVIP_BIT] = mvip_q[h];
      en_msi[h] = msip_q[h] & mie_i[h*XPR_LEN + MSIP_BIT];
      en_mti[h] = mtip_q[h] & mie_i[h*XPR_LEN + MTIP_BIT];
      en_mei[h] = meip_q[h] & mie_i[h*XPR_LEN + MEIP_BIT];
      en_mvi[h] = mvip_q[h] & mie_i[h*XPR_LEN + MVIP_BIT];
    end
    eligible = mstatus_mie_i & (en_msi | en_mti | en_mei | en_mvi);
  end

  // Per-hart request FSM: arbitrate in IDLE, freeze cause in REQ.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    irq_req_o = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      irq_req_o[h] = (state_q[h] == REQ);
      case (state_q[h])
        IDLE: begin
          if (eligible[h]) begin
            state_d[h] = REQ;
            if (en_mei[h])      cause_d[h] = CAUSE_MEI;
            else if (en_msi[h]) cause_d[h] = CAUSE_MSI;
            else if (en_mti[h]) cause_d[h] = CAUSE_MTI;
            else                cause_d[h] = CAUSE_MVI;
          end
        end
        REQ: begin
          if (irq_ack_i[h])      state_d[h] = ACK;
          else if (!eligible[h]) state_d[h] = IDLE;
        end
        ACK:     state_d[h] = IDLE;
        default: state_d[h] = IDLE;
      endcase
    end
  end

  // FSM state and frozen cause registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= {NUM_HARTS{IDLE}};
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign irq_cause_o = cause_q;

endmodule

// File: tb/tb_pito_irq_ctrl.sv
// Directed bench for pito_irq_ctrl: a per-cycle vector table run on one hart,
// plus hand-written sequences for reset, cause freezing and all-hart arbitration.
module tb_pito_irq_ctrl;
  localparam int NH = 8;
  localparam int XL = 32;

  localparam logic [31:0] C_E = 32'h8000000B;
  localparam logic [31:0] C_S = 32'h80000003;
  localparam logic [31:0] C_T = 32'h80000007;
  localparam logic [31:0] C_V = 32'h80000010;

  logic clk = 1'b0;
  logic rst;
  logic [NH-1:0] sw_set, sw_clr, timer, ext, mvu, mst, ack;
  logic [NH*XL-1:0] mie;
  logic [NH*XL-1:0] mip_o;
  logic [NH-1:0] irq_req_o;
  logic [NH*XL-1:0] irq_cause_o;

  int n_err = 0;
  int n_chk = 0;

  pito_irq_ctrl #(.NUM_HARTS(NH), .XPR_LEN(XL)) dut (
    .clk(clk), .rst(rst),
    .sw_irq_set_i(sw_set), .sw_irq_clr_i(sw_clr),
    .timer_irq_i(timer), .ext_irq_i(ext), .mvu_irq_i(mvu),
    .mstatus_mie_i(mst), .mie_i(mie), .irq_ack_i(ack),
    .mip_o(mip_o), .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sws, swc, tmr, ext, mvu, mst, ack;
    logic [31:0] mie;
    logic [31:0] mip;
    logic req;
    logic [31:0] cause;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t v(input logic sws, input logic swc, input logic tmr,
                             input logic e, input logic m, input logic ms,
                             input logic a, input logic [31:0] mi,
                             input logic [31:0] mp, input logic rq,
                             input logic [31:0] c);
    vec_t r;
    r.sws = sws; r.swc = swc; r.tmr = tmr; r.ext = e; r.mvu = m;
    r.mst = ms; r.ack = a; r.mie = mi; r.mip = mp; r.req = rq; r.cause = c;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    sw_set = '0; sw_clr = '0; timer = '0; ext = '0;
    mvu = '0; mst = '0; ack = '0; mie = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] mip_of(input int h);
    return mip_o[h*XL +: XL];
  endfunction

  function automatic logic [31:0] cause_of(input int h);
    return irq_cause_o[h*XL +: XL];
  endfunction

  initial begin
    int th;
    logic [31:0] mie_c[NH];
    logic [31:0] exp_c[NH];

    //        sws swc tmr ext mvu mst ack mie         mip        req cause
    tbl[0]  = v(0, 0, 1, 0, 0, 1, 0, 32'h80,    32'h80,    0, 32'h0);
    tbl[1]  = v(0, 0, 1, 0, 0, 1, 0, 32'h80,    32'h80,    1, C_T);
    tbl[2]  = v(0, 0, 1, 1, 0, 1, 0, 32'h880,   32'h880,   1, C_T);
    tbl[3]  = v(0, 0, 1, 1, 0, 1, 1, 32'h880,   32'h880,   0, C_T);
    tbl[4]  = v(0, 0, 1, 1, 0, 1, 0, 32'h880,   32'h880,   0, C_T);
    tbl[5]  = v(0, 0, 1, 1, 0, 1, 0, 32'h880,   32'h880,   1, C_E);
    tbl[6]  = v(0, 0, 0, 0, 0, 1, 0, 32'h880,   32'h0,     1, C_E);
    tbl[7]  = v(0, 0, 0, 0, 0, 1, 0, 32'h880,   32'h0,     0, C_E);
    tbl[8]  = v(1, 0, 0, 0, 0, 0, 0, 32'h8,     32'h8,     0, C_E);
    tbl[9]  = v(0, 0, 0, 0, 0, 0, 0, 32'h8,     32'h8,     0, C_E);
    tbl[10] = v(0, 0, 0, 0, 0, 1, 0, 32'h8,     32'h8,     1, C_S);
    tbl[11] = v(0, 0, 0, 0, 0, 1, 1, 32'h8,     32'h8,     0, C_S);
    tbl[12] = v(0, 0, 0, 0, 0, 1, 0, 32'h8,     32'h8,     0, C_S);
    tbl[13] = v(0, 0, 0, 0, 0, 1, 0, 32'h8,     32'h8,     1, C_S);
    tbl[14] = v(1, 1, 0, 0, 0, 1, 0, 32'h8,     32'h8,     1, C_S);
    tbl[15] = v(0, 1, 0, 0, 0, 1, 0, 32'h8,     32'h0,     1, C_S);
    tbl[16] = v(0, 0, 0, 0, 0, 1, 0, 32'h8,     32'h0,     0, C_S);
    tbl[17] = v(0, 0, 0, 0, 1, 1, 0, 32'h10000, 32'h10000, 0, C_S);
    tbl[18] = v(0, 0, 0, 0, 0, 1, 0, 32'h10000, 32'h10000, 1, C_V);
    tbl[19] = v(0, 0, 0, 0, 0, 1, 1, 32'h10000, 32'h0,     0, C_V);
    tbl[20] = v(0, 0, 0, 0, 0, 1, 0, 32'h10000, 32'h0,     0, C_V);
    tbl[21] = v(0, 0, 0, 0, 0, 1, 0, 32'h10000, 32'h0,     0, C_V);
    tbl[22] = v(0, 0, 0, 0, 1, 1, 0, 32'h10000, 32'h10000, 0, C_V);
    tbl[23] = v(0, 0, 0, 0, 0, 1, 0, 32'h10000, 32'h10000, 1, C_V);
    tbl[24] = v(0, 0, 0, 0, 1, 1, 1, 32'h10000, 32'h10000, 0, C_V);
    tbl[25] = v(0, 0, 0, 0, 0, 1, 0, 32'h10000, 32'h10000, 0, C_V);
    tbl[26] = v(0, 0, 0, 0, 0, 1, 0, 32'h10000, 32'h10000, 1, C_V);
    tbl[27] = v(0, 0, 0, 0, 0, 1, 1, 32'h10000, 32'h0,     0, C_V);
    tbl[28] = v(0, 0, 0, 0, 0, 1, 0, 32'h10000, 32'h0,     0, C_V);
    tbl[29] = v(0, 0, 0, 0, 0, 1, 1, 32'h10000, 32'h0,     0, C_V);

    // Reset with every source high, then release and enable hart 0.
    clear_inputs();
    rst = 1'b1;
    timer = '1; ext = '1; sw_set = '1;
    for (int h = 0; h < NH; h++) mie[h*XL +: XL] = 32'h888;
    tick();
    tick();
    chk("rst_mip_any", {31'b0, |mip_o}, 32'h0);
    chk("rst_req", {24'b0, irq_req_o}, 32'h0);
    chk("rst_cause_any", {31'b0, |irq_cause_o}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rel_mip0", mip_of(0), 32'h888);
    chk("rel_req_mie_off", {24'b0, irq_req_o}, 32'h0);
    sw_set = '0;
    tick();
    chk("rel_req_mie_off2", {24'b0, irq_req_o}, 32'h0);
    mst[0] = 1'b1;
    tick();
    chk("rel_req0", {24'b0, irq_req_o}, 32'h1);
    chk("rel_cause0", cause_of(0), C_E);

    // Vector table on hart 3.
    do_reset();
    th = 3;
    for (int i = 0; i < 30; i++) begin
      clear_inputs();
      sw_set[th] = tbl[i].sws;
      sw_clr[th] = tbl[i].swc;
      timer[th]  = tbl[i].tmr;
      ext[th]    = tbl[i].ext;
      mvu[th]    = tbl[i].mvu;
      mst[th]    = tbl[i].mst;
      ack[th]    = tbl[i].ack;
      mie[th*XL +: XL] = tbl[i].mie;
      tick();
      chk($sformatf("tbl%0d_mip", i), mip_of(th), tbl[i].mip);
      chk($sformatf("tbl%0d_req", i), {24'b0, irq_req_o}, {24'b0, 8'(tbl[i].req) << th});
      chk($sformatf("tbl%0d_cause", i), cause_of(th), tbl[i].cause);
    end
    clear_inputs();

    // Hart 5: frozen timer cause survives a later external interrupt.
    do_reset();
    timer[5] = 1'b1; mst[5] = 1'b1; mie[5*XL +: XL] = 32'h880;
    tick();
    tick();
    chk("h5_req", {24'b0, irq_req_o}, 32'h20);
    chk("h5_cause_t", cause_of(5), C_T);
    ext[5] = 1'b1;
    tick();
    tick();
    chk("h5_hold_req", {24'b0, irq_req_o}, 32'h20);
    chk("h5_hold_cause", cause_of(5), C_T);
    ack[5] = 1'b1;
    tick();
    ack[5] = 1'b0;
    chk("h5_ack_gap", {24'b0, irq_req_o}, 32'h0);
    tick();
    chk("h5_idle", {24'b0, irq_req_o}, 32'h0);
    tick();
    chk("h5_req2", {24'b0, irq_req_o}, 32'h20);
    chk("h5_cause_e", cause_of(5), C_E);

    // All harts at once with distinct enables, then asynchronous reset mid-REQ.
    do_reset();
    mie_c = '{32'h10888, 32'h88, 32'h10080, 32'h10000, 32'h808, 32'h10008, 32'h0, 32'h10880};
    exp_c = '{C_E, C_S, C_T, C_V, C_E, C_S, 32'h0, C_E};
    for (int h = 0; h < NH; h++) mie[h*XL +: XL] = mie_c[h];
    mst = '1; timer = '1; ext = '1; sw_set = '1; mvu = '1;
    tick();
    sw_set = '0; mvu = '0;
    chk("all_mip0", mip_of(0), 32'h10888);
    tick();
    chk("all_req", {24'b0, irq_req_o}, 32'hBF);
    for (int h = 0; h < NH; h++) chk($sformatf("all_cause%0d", h), cause_of(h), exp_c[h]);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", {24'b0, irq_req_o}, 32'h0);
    chk("async_rst_cause", {31'b0, |irq_cause_o}, 32'h0);
    chk("async_rst_mip", {31'b0, |mip_o}, 32'h0);
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pito_irq_ctrl.md
Name: pito_irq_ctrl

Overview:
- Per-hart machine interrupt controller for the 8-hart barrel core.
- Captures the software, timer, external and MVU interrupt sources, and drives the MIP image into the CSR file.
- Arbitrates enabled pending sources and presents one frozen trap request per hart, with its mcause value, to the trap/CSR stage.
- Retires the request on acknowledge.

Parameters:
- NUM_HARTS, 8, number of hardware threads.
- HART_CNT_WIDTH, $clog2(NUM_HARTS), hart index width.
- XPR_LEN, 32, register width of mip/mcause words.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- sw_irq_set_i  input  NUM_HARTS  one-cycle pulse per hart; sets MSIP (CSR write of MIP.MSIP=1)
- sw_irq_clr_i  input  NUM_HARTS  one-cycle pulse per hart; clears MSIP
- timer_irq_i  input  NUM_HARTS  level timer interrupt per hart
- ext_irq_i  input  NUM_HARTS  level external interrupt per hart
- mvu_irq_i  input  NUM_HARTS  one-cycle MVU job-done pulse per hart
- mstatus_mie_i  input  NUM_HARTS  global machine interrupt enable per hart
- mie_i  input  NUM_HARTS*XPR_LEN  per-hart MIE word; only bits 3, 7, 11 and 16 are used
- irq_ack_i  input  NUM_HARTS  pulse: trap taken for hart h
- mip_o  output  NUM_HARTS*XPR_LEN  per-hart MIP image
- irq_req_o  output  NUM_HARTS  trap request per hart
- irq_cause_o  output  NUM_HARTS*XPR_LEN  mcause value for the request, valid while irq_req_o is high

Behaviour:
- Reset (asynchronous, rst=1): all pending bits 0, irq_req_o=0, irq_cause_o=0, mip_o=0, every hart FSM in IDLE.
- Pending state, per hart:
  - MSIP is a register. Set on sw_irq_set_i, cleared on sw_irq_clr_i. If both arrive in the same cycle, set wins. Acknowledge never clears MSIP.
  - MTIP and MEIP follow timer_irq_i and ext_irq_i directly; they are not latched.
  - MVIP is a sticky register set by a mvu_irq_i pulse. It is cleared only by irq_ack_i while the frozen cause is MVU_INTR. If a new mvu_irq_i pulse arrives in the same cycle as that clear, set wins, so no pulse is lost.
- mip_o layout per hart: bit 3 = MSIP, bit 7 = MTIP, bit 11 = MEIP, bit 16 = MVIP; all other bits 0. Registered, one cycle after the source.
- eligible[h] = mstatus_mie_i[h] & |(mip[h] & mie_i[h]).
- Priority, highest first: MEIP (cause 0x8000000B), MSIP (0x80000003), MTIP (0x80000007), MVIP (0x80000010).
- FSM per hart, fully independent across harts:
  - IDLE: if eligible, go to REQ, latching the highest-priority cause into irq_cause_o. irq_req_o rises on the next edge.
  - REQ: irq_req_o=1 and irq_cause_o is held constant, even if a higher-priority source arrives.
    - On irq_ack_i, go to ACK.
    - If eligible drops with no ack, withdraw: go to IDLE and drop irq_req_o next cycle.
    - If ack and withdrawal occur in the same cycle, ack wins.
  - ACK: one cycle with irq_req_o=0, during which MVIP is cleared if applicable. Then IDLE, where arbitration resumes. This gives a minimum one-cycle gap between requests.
- irq_ack_i in IDLE or ACK is ignored.
- Latency: level source asserted at edge N → mip_o at N+1, irq_req_o at N+2.
- Reset during REQ drops irq_req_o immediately (asynchronous) and loses any un-acked MVIP.
- Writes to mie_i or mstatus_mie_i take effect on the next arbitration; they never alter a frozen cause.

Optional Feature:
- Macro: PITO_IRQ_SYNC_EN.
- Defined: timer_irq_i and ext_irq_i each pass through a 2-flop synchronizer (reset to 0) before pending logic, so level-source latency becomes N+3 for mip_o and N+4 for irq_req_o.
- Not defined: no synchronizer; levels must already be clk-synchronous.
- Pulse inputs (sw_irq_*, mvu_irq_i) are never synchronized.

Test Plan:
- Reset with all sources high, release: hart 0 mip_o=0x00000888 one cycle after rst falls; no request while mstatus_mie_i=0; set mstatus_mie_i[0]=1 with mie_i[0]=0x888 → irq_req_o[0]=1, irq_cause_o=0x8000000B.
- mvu_irq_i[3] pulse, mie_i[3]=0x10000, MIE=1 → mip_o[3] bit 16 set next cycle, irq_req_o[3] two cycles after pulse, cause 0x80000010; ack → bit 16 cleared, req low 1 cycle, stays idle.
- mvu_irq_i[3] pulse in the same cycle as its ack → MVIP remains 1, new request issued after the ACK cycle.
- Hart 5 in REQ with cause 0x80000007; assert ext_irq_i[5] → cause stays 0x80000007 until ack, next request 0x8000000B.
- Hart 2 in REQ (MSIP); sw_irq_clr_i[2] with no ack → irq_req_o[2] drops next cycle; sw_irq_set_i and sw_irq_clr_i together → MSIP=1.
- Simultaneous sources on harts 0–7 with distinct enables → each hart's cause is independent and correct; assert rst mid-REQ → all irq_req_o=0 immediately.
